exp_arbiter: RTL and testbench
==============================

# exp_arbiter

Shares one floating-point `exponential` engine between `NUM_REQ` requesters, such as softmax lanes or activation units in the CNN datapath. The block grants requesters round-robin and launches the engine with a one-cycle start pulse. It waits for `exp_done`, then returns the result to the granted requester with a one-cycle response pulse. One operation is in flight at a time.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `EXPONENT_WIDTH`, 8: float exponent width.
- `MANTISSA_WIDTH`, 23: float mantissa width.
- `DATA_WIDTH`, `EXPONENT_WIDTH+MANTISSA_WIDTH+1`: derived; do not override.
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles. Used only with `EXP_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_data`  in  NUM_REQ*DATA_WIDTH  operand x; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `rsp_valid`  out  NUM_REQ  one-hot result strobe, one cycle long.
- `rsp_data`  out  DATA_WIDTH  e^x; shared by all requesters, qualified by `rsp_valid`.
- `rsp_err`  out  1  timeout flag; qualified by `rsp_valid`.
- `exp_start`  out  1  engine launch pulse.
- `exp_in`  out  DATA_WIDTH  engine operand.
- `exp_out`  in  DATA_WIDTH  engine result.
- `exp_done`  in  1  engine completion pulse.

## Operation
- State machine: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant the first requester with `req_valid` set, searching upward from `rr_ptr` with wrap-around.
  - Pulse that requester's `req_ready` in the same cycle.
  - Capture its `req_data` into `op_reg`, record `gnt_idx`, go to ISSUE.
  - If no request is pending, stay in IDLE.
- ISSUE: `exp_start`=1 for exactly one cycle, then go to WAIT.
- `exp_in` is driven from `op_reg` and held stable from ISSUE through the end of WAIT.
- WAIT:
  - On `exp_done`=1, capture `exp_out` into `res_reg` and go to RESP.
  - `exp_done` is ignored in every other state.
- RESP:
  - `rsp_valid[gnt_idx]`=1 and `rsp_data`=`res_reg` for one cycle.
  - Set `rr_ptr` = (`gnt_idx`+1) mod `NUM_REQ`, go to IDLE.
- Handshake rules:
  - A requester holds `req_valid` and its data until it sees `req_ready`.
  - `rsp_valid` has no backpressure; the requester must sample it.
  - A requester may re-assert `req_valid` in the cycle after its `rsp_valid`.
- Fairness: with all requesters continuously valid, the grant order is 0,1,…,NUM_REQ-1,0,…
- Dropping `req_valid` without a `req_ready` is legal; that request is simply not granted.
- `rsp_data` keeps its last value outside RESP.

## Timing
- Reset values, all zero:
  - outputs: `req_ready`, `rsp_valid`, `rsp_data`, `rsp_err`, `exp_start`, `exp_in`;
  - internal: `rr_ptr`, `gnt_idx`, `op_reg`, `res_reg`, watchdog counter;
  - state = IDLE.
- Latency, with accept in cycle T and engine latency L (cycles from `exp_start` to `exp_done`):
  - `exp_start` in T+1;
  - `exp_done` in T+1+L;
  - `rsp_valid` in T+2+L;
  - next accept no earlier than T+3+L.
- `rst` mid-operation aborts the operation and returns the block to IDLE with no response. The engine must share `rst` so that no stale `exp_done` arrives afterwards.
- `req_valid` rising in the same cycle as RESP is not granted until the following IDLE cycle.

## Configuration
- Macro: `EXP_ARB_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT, starting from 0.
  - If it reaches `TIMEOUT_CYCLES` without `exp_done`, go to RESP with `rsp_data`=0 and `rsp_err`=1.
  - `exp_done` in the same cycle as the timeout wins: normal result, `rsp_err`=0.
- Undefined: no counter; `rsp_err` is tied to 0; WAIT lasts indefinitely.

## Structure
- Shared package `exp_pkg` holds:
  - the width defaults;
  - the FP constants ONE=32'h3F800000 and ZERO=32'h00000000;
  - the state enum (IDLE, ISSUE, WAIT, RESP).
- One sub-module, `exp_rr_pick`: combinational round-robin picker.
  - Inputs: `req_valid` and `rr_ptr`.
  - Outputs: one-hot grant and grant index.
- FSM, registers and watchdog live in `exp_arbiter`.

## Test plan
- Single request, real `exponential` engine: requester 0, x=32'h00000000 -> `rsp_valid`=4'b0001, `rsp_data`=32'h3F800000, `rsp_err`=0.
- Single request, real engine: requester 2, x=32'h3F800000 -> `rsp_valid`=4'b0100, `rsp_data` within 1e-3 of 2.71828.
- Fairness, engine stub with L=5 returning `exp_in` unchanged: all four requesters valid continuously -> grants 0,1,2,3,0; `rsp_valid` spacing 8 cycles; each `rsp_data` equals that requester's operand.
- Reset mid-operation: assert `rst` in WAIT -> all outputs 0 next edge, no `rsp_valid`; after release, the next request is granted starting from requester 0.
- Timeout, with `EXP_ARB_TIMEOUT_EN` defined: stub never asserts `exp_done` -> `rsp_valid` 64 cycles after entering WAIT, with `rsp_err`=1 and `rsp_data`=0.
- Spurious `exp_done` pulsed in IDLE and ISSUE -> no `rsp_valid`; the real result returns normally.

Source files
------------

// File: rtl/exp_pkg.sv
// Shared definitions for the exponential-engine arbiter: width defaults,
// float constants and the arbiter state encoding.
package exp_pkg;

    localparam int NUM_REQ_DEF        = 4;
    localparam int EXPONENT_WIDTH_DEF = 8;
    localparam int MANTISSA_WIDTH_DEF = 23;
    localparam int DATA_WIDTH_DEF     = EXPONENT_WIDTH_DEF + MANTISSA_WIDTH_DEF + 1;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    localparam logic [31:0] ONE  = 32'h3F800000;
    localparam logic [31:0] ZERO = 32'h00000000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/exp_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above
// rr_ptr, wrapping around, as a one-hot grant plus its index.
module exp_rr_pick
    import exp_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!gnt_any && req_valid[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exp_arbiter.sv
// Round-robin arbiter sharing one exponential engine among NUM_REQ requesters.
// Optional watchdog on the engine wait is enabled by defining EXP_ARB_TIMEOUT_EN.
module exp_arbiter
    import exp_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int EXPONENT_WIDTH = EXPONENT_WIDTH_DEF,
    parameter int MANTISSA_WIDTH = MANTISSA_WIDTH_DEF,
    parameter int DATA_WIDTH     = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          exp_start,
    output logic [DATA_WIDTH-1:0]         exp_in,
    input  logic [DATA_WIDTH-1:0]         exp_out,
    input  logic                          exp_done
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       gnt_idx;
    logic [DATA_WIDTH-1:0]  op_reg;
    logic [DATA_WIDTH-1:0]  res_reg;
    logic [DATA_WIDTH-1:0]  req_ops [NUM_REQ];
    logic [NUM_REQ-1:0]     pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   timeout_hit;

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("exp_arbiter: NUM_REQ must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("exp_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_ops[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    exp_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .gnt       (pick_gnt),
        .gnt_idx   (pick_idx),
        .gnt_any   (pick_any)
    );

    // Accept strobe must land in the grant cycle itself, so it is decoded, not registered.
    assign req_ready = (state == IDLE && !rst) ? pick_gnt : '0;
    assign exp_in    = op_reg;
    assign rsp_data  = res_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            op_reg    <= '0;
            res_reg   <= '0;
            rsp_valid <= '0;
            exp_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        op_reg    <= req_ops[pick_idx];
                        gnt_idx   <= pick_idx;
                        exp_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    exp_start <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (exp_done || timeout_hit) begin
                        res_reg   <= exp_done ? exp_out : '0;
                        rsp_valid <= NUM_REQ'(1) << gnt_idx;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    rr_ptr    <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             err_reg;

    // A done arriving in the expiry cycle wins, hence the !exp_done term.
    assign timeout_hit = (state == WAIT) && !exp_done && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            err_reg <= 1'b0;
        end else begin
            if (state == WAIT && !exp_done && !timeout_hit) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (state == WAIT && (exp_done || timeout_hit)) begin
                err_reg <= timeout_hit;
            end
        end
    end

    assign rsp_err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_exp_arbiter.sv
// Self-checking bench for exp_arbiter with a behavioural engine stub of
// programmable latency; timeout cases build only with EXP_ARB_TIMEOUT_EN.
module tb_exp_arbiter;
    import exp_pkg::*;

    localparam logic [31:0] E_VAL = 32'h402DF854;  // e = 2.7182817
    localparam logic [31:0] NAN_V = 32'h7FC00000;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic         rsp_err;
    logic         exp_start;
    logic [31:0]  exp_in;
    logic [31:0]  exp_out;
    logic         exp_done;

    int   n_cmp  = 0;
    int   n_fail = 0;

    int   eng_lat  = 3;
    bit   eng_mode = 1'b0;   // 0: identity, 1: exp lookup
    bit   eng_mute = 1'b0;
    bit   spur     = 1'b0;
    logic [7:0] eng_cnt;

    exp_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .exp_start (exp_start),
        .exp_in    (exp_in),
        .exp_out   (exp_out),
        .exp_done  (exp_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_model(input logic [31:0] x);
        if (x == ZERO) return ONE;
        if (x == ONE)  return E_VAL;
        return NAN_V;
    endfunction

    // Engine stub: done pulses eng_lat cycles after the start cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_cnt <= 8'd0;
            exp_out <= 32'd0;
        end else if (exp_start) begin
            eng_cnt <= 8'(eng_lat);
            exp_out <= eng_mode ? exp_model(exp_in) : exp_in;
        end else if (eng_cnt != 8'd0) begin
            eng_cnt <= eng_cnt - 8'd1;
        end
    end
    assign exp_done = ((eng_cnt == 8'd1) && !eng_mute) || spur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return -1;
    endfunction

    // One complete transaction; called at posedge+1 of an IDLE cycle.
    task automatic run_txn(input string tag, input int idx, input logic [31:0] x,
                           input int lat, input bit mode, input bit mute,
                           input logic [31:0] exp_data, input bit exp_err, input int exp_lat);
        int cyc;
        eng_lat  = lat;
        eng_mode = mode;
        eng_mute = mute;
        req_data[idx*32 +: 32] = x;
        req_valid = 4'(1) << idx;
        #2;
        cyc = 0;
        while (req_ready == 4'd0 && cyc < 20) begin step(); #2; cyc++; end
        check({tag, "_accept"}, req_ready, 4'(1) << idx);
        step();
        req_valid = 4'd0;
        #2;
        check({tag, "_exp_start"}, exp_start, 1'b1);
        check({tag, "_exp_in"}, exp_in, x);
        cyc = 1;
        while (rsp_valid == 4'd0 && cyc < 200) begin step(); #2; cyc++; end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_rsp_valid"}, rsp_valid, 4'(1) << idx);
        check({tag, "_rsp_data"}, rsp_data, exp_data);
        check({tag, "_rsp_err"}, rsp_err, exp_err);
        step();
        #2;
        check({tag, "_rsp_pulse"}, rsp_valid, 4'd0);
        check({tag, "_rsp_hold"}, rsp_data, exp_data);
        eng_mute = 1'b0;
    endtask

    typedef struct {
        int          idx;
        logic [31:0] x;
        int          lat;
        bit          mode;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "bench timed out");
    end

    initial begin
        int cyc;
        bit seen;
        logic [31:0] fd [4];
        int          g_idx [$];
        int          r_cyc [$];
        logic [3:0]  r_val [$];
        logic [31:0] r_dat [$];

        vecs[0] = '{idx: 0, x: ZERO,          lat: 3, mode: 1'b1, exp_data: ONE};
        vecs[1] = '{idx: 2, x: ONE,           lat: 1, mode: 1'b1, exp_data: E_VAL};
        vecs[2] = '{idx: 3, x: 32'hC0000000,  lat: 2, mode: 1'b0, exp_data: 32'hC0000000};
        vecs[3] = '{idx: 3, x: ONE,           lat: 4, mode: 1'b1, exp_data: E_VAL};
        vecs[4] = '{idx: 1, x: 32'h12345678,  lat: 7, mode: 1'b0, exp_data: 32'h12345678};

        // Reset state, with requests pending to show req_ready stays low.
        rst       = 1'b1;
        req_valid = 4'hF;
        req_data  = '0;
        #2;
        check("reset_outputs", {req_ready, rsp_valid, rsp_data, rsp_err, exp_start, exp_in}, 0);
        step();
        step();
        rst       = 1'b0;
        req_valid = 4'd0;
        step();

        // Spurious done in IDLE and ISSUE must be ignored.
        eng_lat  = 3;
        eng_mode = 1'b0;
        spur     = 1'b1;
        #2;
        step();
        spur = 1'b0;
        req_data[31:0] = 32'h3E99999A;
        req_valid = 4'b0001;
        #2;
        check("spur_idle_no_rsp", rsp_valid, 4'd0);
        check("spur_accept", req_ready, 4'b0001);
        step();
        req_valid = 4'd0;
        spur = 1'b1;
        #2;
        check("spur_issue_start", exp_start, 1'b1);
        step();
        spur = 1'b0;
        #2;
        check("spur_issue_no_rsp", rsp_valid, 4'd0);
        cyc = 2;
        while (rsp_valid == 4'd0 && cyc < 200) begin step(); #2; cyc++; end
        check("spur_latency", cyc, 5);
        check("spur_rsp_valid", rsp_valid, 4'b0001);
        check("spur_rsp_data", rsp_data, 32'h3E99999A);
        step();

        // Table of single transactions: latency is accept + L + 2.
        foreach (vecs[i]) begin
            run_txn($sformatf("v%0d", i), vecs[i].idx, vecs[i].x, vecs[i].lat,
                    vecs[i].mode, 1'b0, vecs[i].exp_data, 1'b0, vecs[i].lat + 2);
            step();
        end

        // Reset in WAIT: everything clears, no response, pointer back to 0.
        eng_lat  = 6;
        eng_mode = 1'b0;
        req_data[64 +: 32] = 32'hA5A5A5A5;
        req_valid = 4'b0100;
        #2;
        check("rst_mid_accept", req_ready, 4'b0100);
        step();
        req_valid = 4'd0;
        step();
        step();
        rst = 1'b1;
        #2;
        check("rst_mid_outputs", {req_ready, rsp_valid, rsp_data, rsp_err, exp_start, exp_in}, 0);
        step();
        step();
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            #2;
            if (rsp_valid != 4'd0 || exp_start) seen = 1'b1;
        end
        check("rst_mid_no_rsp", seen, 1'b0);

        // Fairness: all valid, L=5 -> grants 0,1,2,3,0 every 8 cycles.
        eng_lat  = 5;
        eng_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fd[i] = 32'h40100000 + 32'(i * 32'h11111);
            req_data[i*32 +: 32] = fd[i];
        end
        req_valid = 4'hF;
        for (int c = 0; c < 40; c++) begin
            #2;
            if (req_ready != 4'd0) g_idx.push_back(oh2idx(req_ready));
            if (rsp_valid != 4'd0) begin
                r_cyc.push_back(c);
                r_val.push_back(rsp_valid);
                r_dat.push_back(rsp_data);
            end
            step();
        end
        req_valid = 4'd0;
        check("fair_grant_count", g_idx.size(), 5);
        check("fair_rsp_count", r_cyc.size(), 5);
        for (int k = 0; k < g_idx.size() && k < 5; k++)
            check($sformatf("fair_grant%0d", k), g_idx[k], k % 4);
        for (int k = 0; k < r_cyc.size() && k < 5; k++) begin
            check($sformatf("fair_rsp_cycle%0d", k), r_cyc[k], 7 + 8 * k);
            check($sformatf("fair_rsp_valid%0d", k), r_val[k], 4'(1) << (k % 4));
            check($sformatf("fair_rsp_data%0d", k), r_dat[k], fd[k % 4]);
        end
        step();
        step();

`ifdef EXP_ARB_TIMEOUT_EN
        // Engine never answers: response 64 cycles after WAIT entry, with error.
        run_txn("timeout", 2, 32'h3F000000, 10, 1'b0, 1'b1, 32'h0, 1'b1, 66);
        step();
        // Done on the last WAIT cycle beats the watchdog.
        run_txn("timeout_race", 1, 32'h3F000000, 64, 1'b0, 1'b0, 32'h3F000000, 1'b0, 66);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
